// File: rtl/ql_cfg_pkg.sv
// Shared types and default geometry for the memory-bank configuration writer.
package ql_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_DONE
  } cfg_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_BL_WIDTH      = 512;
  localparam int unsigned DEF_WL_ROWS       = 398;
  localparam int unsigned DEF_WL_PULSE      = 2;
  localparam int unsigned DEF_WORDS_PER_ROW = DEF_BL_WIDTH / DEF_DATA_W;
  localparam int unsigned DEF_ROW_W         = clog2_min1(DEF_WL_ROWS);
  localparam int unsigned DEF_CNT_W         = clog2_min1(DEF_WORDS_PER_ROW);

endpackage

// File: rtl/ql_membank_cfg_writer_if.sv
// Valid/ready bitstream word stream feeding the configuration writer.
interface ql_membank_cfg_writer_if #(
  parameter int unsigned DATA_W = ql_cfg_pkg::DEF_DATA_W
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ql_cfg_wl_decoder.sv
// Registered row index to one-hot word-line decoder; all lines low when disabled.
module ql_cfg_wl_decoder #(
  parameter int unsigned WL_ROWS = 398,
  parameter int unsigned ROW_W   = 9
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [ROW_W-1:0]   row_i,
  output logic [0:WL_ROWS-1] wl_o
);
  logic [0:WL_ROWS-1] wl_q, wl_d;

  always_comb begin
    wl_d = '0;
    for (int unsigned r = 0; r < WL_ROWS; r++) begin
      if (en_i && (row_i == ROW_W'(r))) wl_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) wl_q <= '0;
    else       wl_q <= wl_d;
  end

  assign wl_o = wl_q;
endmodule

// File: rtl/ql_membank_cfg_writer.sv
// Streams bitstream words into a BL row, then strobes the row's WL; repeats for every row.
module ql_membank_cfg_writer
  import ql_cfg_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned BL_WIDTH = DEF_BL_WIDTH,
  parameter int unsigned WL_ROWS  = DEF_WL_ROWS,
  parameter int unsigned WL_PULSE = DEF_WL_PULSE
) (
  input  logic                            clk,
  input  logic                            global_reset,
  input  logic                            start,
  ql_membank_cfg_writer_if.slave          s,
  output logic [0:BL_WIDTH-1]             bl,
  output logic [0:WL_ROWS-1]              wl,
  output logic                            busy,
  output logic                            cfg_done,
  output logic [clog2_min1(WL_ROWS)-1:0]  row_idx
);
  localparam int unsigned WORDS_PER_ROW = BL_WIDTH / DATA_W;
  localparam int unsigned ROW_W         = clog2_min1(WL_ROWS);
  localparam int unsigned CNT_W         = clog2_min1(WORDS_PER_ROW);
  localparam int unsigned PCNT_W        = clog2_min1(WL_PULSE);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WORDS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(WL_ROWS - 1);
  localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(WL_PULSE - 1);

  cfg_state_e          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [0:BL_WIDTH-1] bl_q, bl_d;

  always_ff @(posedge clk) begin
    if (global_reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      bl_q    <= bl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    bl_d    = bl_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (s.s_valid) begin
          // bl ascends, so the slice's lowest index takes s_data's MSB.
          bl_d[32'(cnt_q) * DATA_W +: DATA_W] = s.s_data;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_SETUP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SETUP: begin
        pcnt_d  = '0;
        state_d = ST_PULSE;
      end
      ST_PULSE: begin
        if (pcnt_q == PULSE_LAST) state_d = ST_HOLD;
        else                      pcnt_d  = pcnt_q + PCNT_W'(1);
      end
      ST_HOLD: begin
        if (row_q == ROW_LAST) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoder registers its output, so it is enabled from the next state to line up with PULSE.
  ql_cfg_wl_decoder #(
    .WL_ROWS (WL_ROWS),
    .ROW_W   (ROW_W)
  ) u_wl_dec (
    .clk   (clk),
    .rst_i (global_reset),
    .en_i  (state_d == ST_PULSE),
    .row_i (row_q),
    .wl_o  (wl)
  );

  assign s.s_ready = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_SETUP) ||
                     (state_q == ST_PULSE) || (state_q == ST_HOLD);
  assign cfg_done  = (state_q == ST_DONE);
  assign bl        = bl_q;
  assign row_idx   = row_q;
endmodule

// File: tb/tb_ql_membank_cfg_writer.sv
// Randomized bench for ql_membank_cfg_writer against a row-schedule reference model.
module tb_ql_membank_cfg_writer;
  import ql_cfg_pkg::*;

  localparam int DW          = DEF_DATA_W;
  localparam int BLW         = DEF_BL_WIDTH;
  localparam int ROWS        = DEF_WL_ROWS;
  localparam int PW          = DEF_WL_PULSE;
  localparam int WPR         = BLW / DW;
  localparam int ROW_PERIOD  = WPR + 1 + PW + 1;
  localparam int PASS_CYCLES = 7960;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 global_reset, start;
  logic [0:BLW-1]       bl;
  logic [0:ROWS-1]      wl;
  logic                 busy, cfg_done;
  logic [DEF_ROW_W-1:0] row_idx;

  ql_membank_cfg_writer_if #(.DATA_W(DW)) sif ();

  ql_membank_cfg_writer #(
    .DATA_W   (DW),
    .BL_WIDTH (BLW),
    .WL_ROWS  (ROWS),
    .WL_PULSE (PW)
  ) dut (
    .clk          (clk),
    .global_reset (global_reset),
    .start        (start),
    .s            (sif),
    .bl           (bl),
    .wl           (wl),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .row_idx      (row_idx)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  words [ROWS][WPR];
  logic [0:BLW-1] bl_row0, bl_prev, final_bl;
  int             first_done;

  function automatic logic [0:BLW-1] expected_bl(input int r);
    logic [0:BLW-1] v;
    logic [DW-1:0]  w;
    v = '0;
    for (int k = 0; k < WPR; k++) begin
      w = words[r][k];
      for (int i = 0; i < DW; i++) v[k*DW + i] = w[DW-1-i];
    end
    return v;
  endfunction

  function automatic logic [0:ROWS-1] onehot(input int r);
    logic [0:ROWS-1] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic randomize_words();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < WPR; k++) words[r][k] = $urandom;
  endtask

  // Any active word line must be one-hot, outside LOAD, and see a frozen bl.
  always @(negedge clk) begin
    if ((|wl) === 1'b1) begin
      checks++;
      if ($countones(wl) != 1 || bl !== bl_prev || sif.s_ready !== 1'b0) begin
        errors++;
        $display("FAIL wl_invariant: ones=%0d bl_changed=%0b s_ready=%b, required ones=1 bl_changed=0 s_ready=0",
                 $countones(wl), (bl !== bl_prev), sif.s_ready);
      end
    end
    bl_prev <= bl;
  end

  // Drives one pass and checks every cycle against the expected row schedule.
  task automatic run_pass(input int stall_row, input int stall_word, input int stall_len,
                          input int abort_row, input int glitch_t, output int done_t);
    int L [ROWS+1];
    int end_t, pr, pk, stalled, er, off, ld;
    logic            exp_ready, exp_pulse;
    logic [0:ROWS-1] exp_wl;
    L[0] = 0;
    for (int r = 0; r < ROWS; r++)
      L[r+1] = L[r] + ROW_PERIOD + ((r == stall_row) ? stall_len : 0);
    end_t = L[ROWS];
    pr = 0; pk = 0; stalled = 0; er = 0; done_t = -1;

    @(negedge clk);
    start = 1'b1;
    sif.s_valid = 1'b1;
    sif.s_data  = words[0][0];
    for (int t = 0; t <= end_t + 2; t++) begin
      @(negedge clk);
      start = (t == glitch_t);
      while (er < ROWS && t >= L[er+1]) er++;
      exp_ready = 1'b0; exp_pulse = 1'b0; exp_wl = '0;
      if (er < ROWS) begin
        off = t - L[er];
        ld  = WPR + ((er == stall_row) ? stall_len : 0);
        exp_ready = (off < ld);
        exp_pulse = (off > ld) && (off <= ld + PW);
        if (exp_pulse) exp_wl = onehot(er);
      end

      checks++;
      if (wl !== exp_wl) begin
        errors++;
        $display("FAIL wl t=%0d: got %h, required %h", t, wl, exp_wl);
      end
      checks++;
      if (sif.s_ready !== exp_ready) begin
        errors++;
        $display("FAIL s_ready t=%0d: got %b, required %b", t, sif.s_ready, exp_ready);
      end
      checks++;
      if ({busy, cfg_done} !== {(er < ROWS), (er == ROWS)}) begin
        errors++;
        $display("FAIL busy_done t=%0d: got %b%b, required %b%b", t, busy, cfg_done, (er < ROWS), (er == ROWS));
      end
      if (er < ROWS) begin
        checks++;
        if (row_idx !== DEF_ROW_W'(er)) begin
          errors++;
          $display("FAIL row_idx t=%0d: got %0d, required %0d", t, row_idx, er);
        end
      end
      if (exp_pulse || er == ROWS) begin
        checks++;
        if (bl !== expected_bl((er < ROWS) ? er : ROWS - 1)) begin
          errors++;
          $display("FAIL bl_row t=%0d row=%0d: got %h, required %h", t, er, bl,
                   expected_bl((er < ROWS) ? er : ROWS - 1));
        end
      end
      if (exp_pulse && er == 0) bl_row0 = bl;
      if (cfg_done === 1'b1 && done_t < 0) done_t = t;

      if (exp_pulse && er == abort_row) begin
        global_reset = 1'b1;
        start = 1'b0;
        sif.s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({|wl, |bl, busy, sif.s_ready, cfg_done, |row_idx} !== 6'b0) begin
          errors++;
          $display("FAIL abort_reset: got wl|bl|busy|rdy|done|row=%b, required 000000",
                   {|wl, |bl, busy, sif.s_ready, cfg_done, |row_idx});
        end
        global_reset = 1'b0;
        return;
      end

      if (sif.s_ready === 1'b1 && pr == stall_row && pk == stall_word && stalled < stall_len) begin
        sif.s_valid = 1'b0;
        stalled++;
      end else begin
        sif.s_valid = 1'b1;
        if (pr < ROWS) sif.s_data = words[pr][pk];
        if (sif.s_ready === 1'b1 && pr < ROWS) begin
          pk++;
          if (pk == WPR) begin
            pk = 0;
            pr++;
          end
        end
      end
    end
    start = 1'b0;
    sif.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    start        = 1'b0;
    sif.s_valid  = 1'b0;
    sif.s_data   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({|wl, |bl, busy, sif.s_ready, cfg_done, |row_idx} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got wl|bl|busy|rdy|done|row=%b, required 000000",
               {|wl, |bl, busy, sif.s_ready, cfg_done, |row_idx});
    end
    global_reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, sif.s_ready, cfg_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got busy|rdy|done=%b, required 000", {busy, sif.s_ready, cfg_done});
    end
  endtask

  task automatic test_packing();
    int d;
    randomize_words();
    for (int k = 0; k < WPR; k++) words[0][k] = '0;
    words[0][0] = 32'h8000_0001;
    words[0][1] = 32'h0000_0003;
    run_pass(-1, 0, 0, 1, -1, d);
    checks++;
    if (bl_row0[0] !== 1'b1) begin errors++; $display("FAIL pack_bl0: got %b, required 1", bl_row0[0]); end
    checks++;
    if (bl_row0[31] !== 1'b1) begin errors++; $display("FAIL pack_bl31: got %b, required 1", bl_row0[31]); end
    checks++;
    if (bl_row0[62] !== 1'b1) begin errors++; $display("FAIL pack_bl62: got %b, required 1", bl_row0[62]); end
    checks++;
    if (bl_row0[63] !== 1'b1) begin errors++; $display("FAIL pack_bl63: got %b, required 1", bl_row0[63]); end
    checks++;
    if ($countones(bl_row0) != 4) begin
      errors++;
      $display("FAIL pack_ones: got %0d, required 4", $countones(bl_row0));
    end
  endtask

  task automatic test_full_pass();
    int d;
    randomize_words();
    run_pass(-1, 0, 0, -1, 3, d);
    checks++;
    if (d != PASS_CYCLES) begin
      errors++;
      $display("FAIL pass_latency: got %0d, required %0d", d, PASS_CYCLES);
    end
    first_done = d;
    final_bl   = bl;
  endtask

  task automatic test_restart_in_done();
    int d;
    checks++;
    if (cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL done_held: got %b, required 1", cfg_done);
    end
    run_pass(-1, 0, 0, -1, -1, d);
    checks++;
    if (d != first_done) begin
      errors++;
      $display("FAIL restart_latency: got %0d, required %0d", d, first_done);
    end
    checks++;
    if (bl !== final_bl) begin
      errors++;
      $display("FAIL restart_bl: got %h, required %h", bl, final_bl);
    end
  endtask

  task automatic test_stall();
    int d, sr, sw;
    randomize_words();
    sr = $urandom_range(ROWS - 2, 1);
    sw = $urandom_range(WPR - 1, 1);
    run_pass(sr, sw, 5, -1, -1, d);
    checks++;
    if (d != PASS_CYCLES + 5) begin
      errors++;
      $display("FAIL stall_latency row=%0d word=%0d: got %0d, required %0d", sr, sw, d, PASS_CYCLES + 5);
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_full_pass();
    test_restart_in_done();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
